// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and defaults for the shared holding-register arbiter.
// FSM encodings plus default data width and hold length.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_W    = 4;
  localparam int DEF_HOLD = 2;

endpackage

// File: rtl/shared_reg_arbiter_rr_arb2.sv
// Two-way round-robin pick: sole requester wins,
// on a tie the one that did not win last time wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Sequences loads of one shared W-bit register between two
// requesters: round-robin grant, one load cycle, then a hold.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int HOLD_CYCLES = DEF_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] d0,
  input  logic         req1,
  input  logic [W-1:0] d1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [W-1:0] q,
  output logic         q_valid,
  output logic         busy
);

  localparam int CNTW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNTW-1:0] CNT_INIT =
    CNTW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t          state;
  state_t          state_nx;
  logic [CNTW-1:0] cnt;
  logic            last;
  logic            pick_v;
  logic            pick_w;
  logic            take;
  logic            load;
  logic            gnt0_nx;
  logic            gnt1_nx;

  rr_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .valid  (pick_v),
    .winner (pick_w)
  );

  assign busy = (state != IDLE);

  // Next state and next grant; grants only arise on IDLE->LOAD.
  always_comb begin
    state_nx = state;
    gnt0_nx  = 1'b0;
    gnt1_nx  = 1'b0;
    take     = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_v) begin
          state_nx = LOAD;
          take     = 1'b1;
          gnt0_nx  = ~pick_w;
          gnt1_nx  = pick_w;
        end
      end
      LOAD: begin
        load     = 1'b1;
        state_nx = (HOLD_CYCLES > 0) ? HOLD : IDLE;
      end
      HOLD: begin
        if (cnt == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, grant/select, hold counter and data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      sel     <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      state <= state_nx;
      gnt0  <= gnt0_nx;
      gnt1  <= gnt1_nx;
      if (take) begin
        sel  <= pick_w;
        last <= pick_w;
      end
      if (load) begin
        q       <= sel ? d1 : d0;
        q_valid <= 1'b1;
        cnt     <= CNT_INIT;
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: HOLD=2 main
// instance plus a HOLD=0 instance for back-to-back loads.
module tb_shared_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] d0, d1;
  logic       gnt0, gnt1, sel, q_valid, busy;
  logic [3:0] q;

  logic       zreq0, zreq1;
  logic [3:0] zd0, zd1;
  logic       zgnt0, zgnt1, zsel, zq_valid, zbusy;
  logic [3:0] zq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.W(4), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .q(q), .q_valid(q_valid), .busy(busy)
  );

  shared_reg_arbiter #(.W(4), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req0(zreq0), .d0(zd0), .req1(zreq1), .d1(zd1),
    .gnt0(zgnt0), .gnt1(zgnt1), .sel(zsel),
    .q(zq), .q_valid(zq_valid), .busy(zbusy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] zv [3];

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; d0 = 0; d1 = 0;
    zreq0 = 0; zreq1 = 0; zd0 = 0; zd1 = 0;

    // 1: reset state
    step();
    step();
    chk("rst_q", q, 0);
    chk("rst_qv", q_valid, 0);
    chk("rst_g0", gnt0, 0);
    chk("rst_g1", gnt1, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // 2: single request from requester 0
    req0 = 1; d0 = 4'hA;
    step();
    chk("s_g0", gnt0, 1);
    chk("s_g1", gnt1, 0);
    chk("s_busy_l", busy, 1);
    chk("s_q_old", q, 0);
    req0 = 0;
    step();
    chk("s_g0_off", gnt0, 0);
    chk("s_q", q, 4'hA);
    chk("s_qv", q_valid, 1);
    chk("s_busy_h1", busy, 1);
    step();
    chk("s_busy_h0", busy, 1);
    step();
    chk("s_busy_end", busy, 0);

    // 3: tie right after reset, both held high
    do_reset();
    req0 = 1; req1 = 1; d0 = 4'h3; d1 = 4'hC;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t_g0", gnt0, (i % 2 == 0));
      chk("t_g1", gnt1, (i % 2 == 1));
      chk("t_sel", sel, (i % 2 == 1));
      step();
      chk("t_q", q, (i % 2 == 0) ? 4'h3 : 4'hC);
      chk("t_gnt_off", {gnt0, gnt1}, 0);
      step();
      chk("t_hold_gnt", {gnt0, gnt1}, 0);
      step();
      chk("t_idle", busy, 0);
    end
    req0 = 0; req1 = 0;

    // 4: req1 arriving during a req0 hold waits for IDLE
    req0 = 1; d0 = 4'h6;
    step();
    chk("h_g0", gnt0, 1);
    req0 = 0; req1 = 1; d1 = 4'h9;
    step();
    chk("h_q6", q, 4'h6);
    chk("h_g1_a", gnt1, 0);
    step();
    chk("h_g1_b", gnt1, 0);
    step();
    chk("h_g1_c", gnt1, 0);
    step();
    chk("h_g1", gnt1, 1);
    chk("h_sel", sel, 1);
    req1 = 0;
    step();
    chk("h_q9", q, 4'h9);
    step();
    step();
    chk("h_idle", busy, 0);

    // 5: reset during LOAD aborts the load of d1
    do_reset();
    req1 = 1; d1 = 4'h5;
    step();
    chk("r_g1", gnt1, 1);
    rst = 1; req1 = 0;
    step();
    chk("r_q", q, 0);
    chk("r_g1_off", gnt1, 0);
    chk("r_busy", busy, 0);
    chk("r_qv", q_valid, 0);
    rst = 0;
    step();
    chk("r_q_stay", q, 0);
    chk("r_idle", busy, 0);

    // 6: HOLD_CYCLES=0, continuous req0 with changing data
    zv[0] = 4'h1; zv[1] = 4'h2; zv[2] = 4'h7;
    zreq0 = 1;
    for (int i = 0; i < 3; i++) begin
      zd0 = zv[i];
      step();
      chk("z_g0", zgnt0, 1);
      chk("z_busy", zbusy, 1);
      step();
      chk("z_g0_off", zgnt0, 0);
      chk("z_q", zq, zv[i]);
      chk("z_idle", zbusy, 0);
    end
    zreq0 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
